// File: rtl/serial_subtract_ctrl.sv
// Bit-serial WIDTH-bit unsigned subtractor (a - b), one bit per clock, LSB first.
// A full subtractor built from two half_subtractor cells processes one bit per RUN cycle.

module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic b
);

    assign d = x ^ y;
    assign b = ~x & y;

endmodule

module serial_subtract_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_r;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] sr_r;
    logic             bf_r;
    logic [CNT_W-1:0] cnt_r;

    logic             d1_s;
    logic             b1_s;
    logic             d_s;
    logic             b2_s;
    logic             bout_s;
    logic             last_s;
    logic [WIDTH-1:0] sr_next_s;

    // First half stage: x - y; second half stage subtracts the incoming borrow.
    half_subtractor u_hs_xy (
        .x (sa_r[0]),
        .y (sb_r[0]),
        .d (d1_s),
        .b (b1_s)
    );

    half_subtractor u_hs_bin (
        .x (d1_s),
        .y (bf_r),
        .d (d_s),
        .b (b2_s)
    );

    // Combine the cell borrows and form the next result and last-bit flag.
    always_comb begin
        bout_s    = b1_s | b2_s;
        sr_next_s = {d_s, sr_r[WIDTH-1:1]};
        if (cnt_r == CNT_W'(WIDTH - 1)) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Sequencer FSM, operand/result shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= {WIDTH{1'b0}};
            borrow_out <= 1'b0;
            sa_r       <= {WIDTH{1'b0}};
            sb_r       <= {WIDTH{1'b0}};
            sr_r       <= {WIDTH{1'b0}};
            bf_r       <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa_r    <= a;
                        sb_r    <= b;
                        sr_r    <= {WIDTH{1'b0}};
                        bf_r    <= 1'b0;
                        cnt_r   <= {CNT_W{1'b0}};
                        busy    <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    sa_r <= {1'b0, sa_r[WIDTH-1:1]};
                    sb_r <= {1'b0, sb_r[WIDTH-1:1]};
                    bf_r <= bout_s;
                    sr_r <= sr_next_s;
                    // The final bit is folded straight into diff/borrow_out on the DONE entry edge.
                    if (last_s) begin
                        state_r    <= ST_DONE;
                        done       <= 1'b1;
                        diff       <= sr_next_s;
                        borrow_out <= bout_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Self-checking bench for serial_subtract_ctrl (WIDTH=8): directed cases plus
// randomized back-to-back operations against an arithmetic reference model.

module tb_serial_subtract_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int check_cnt;
    int err_cnt;
    int last_diff;
    int last_bor;

    serial_subtract_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_diff(input int x, input int y);
        return (x - y) & 255;
    endfunction

    function automatic int model_bor(input int x, input int y);
        return (x < y) ? 1 : 0;
    endfunction

    // One full operation: start pulse, bounded wait for done, result and pulse-width checks.
    task automatic run_op(input string tag, input int x, input int y);
        int cyc;
        a     = x[W-1:0];
        b     = y[W-1:0];
        start = 1'b1;
        step();
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        check_val({tag, "_busy"}, 32'(busy), 32'd1);
        cyc = 0;
        while (!done && cyc < 20) begin
            step();
            cyc++;
        end
        check_val({tag, "_lat"}, cyc, W);
        check_val({tag, "_diff"}, 32'(diff), model_diff(x, y));
        check_val({tag, "_bor"}, 32'(borrow_out), model_bor(x, y));
        last_diff = model_diff(x, y);
        last_bor  = model_bor(x, y);
        step();
        check_val({tag, "_done_low"}, 32'(done), 32'd0);
        check_val({tag, "_hold"}, 32'(diff), last_diff);
    endtask

    initial begin
        int dcnt;
        int e;
        int last_e;
        int xa;
        int xb;
        int qa[$];
        int qb[$];

        check_cnt = 0;
        err_cnt   = 0;
        rst       = 1'b1;
        start     = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        step();
        step();
        rst = 1'b0;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_diff", 32'(diff), 32'd0);
        check_val("rst_bor", 32'(borrow_out), 32'd0);

        run_op("t1", 8'h05, 8'h03);
        run_op("t2a", 8'h03, 8'h05);
        run_op("t2b", 8'h00, 8'h01);
        run_op("t3a", 8'hA5, 8'hA5);
        run_op("t3b", 8'hFF, 8'h00);

        // T4: start pulse while busy is ignored.
        a     = 8'h37;
        b     = 8'h12;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check_val("t4_diff_stable", 32'(diff), last_diff);
        a     = 8'h10;
        b     = 8'h01;
        start = 1'b1;
        step();
        start = 1'b0;
        dcnt  = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                dcnt++;
                check_val("t4_diff", 32'(diff), model_diff(8'h37, 8'h12));
                check_val("t4_bor", 32'(borrow_out), model_bor(8'h37, 8'h12));
            end
            step();
        end
        check_val("t4_pulses", dcnt, 1);
        check_val("t4_idle", 32'(busy), 32'd0);

        // T5: reset in the middle of RUN aborts the operation.
        a     = 8'h9C;
        b     = 8'hB1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("t5_busy", 32'(busy), 32'd0);
        check_val("t5_done", 32'(done), 32'd0);
        check_val("t5_diff", 32'(diff), 32'd0);
        check_val("t5_bor", 32'(borrow_out), 32'd0);
        dcnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) dcnt++;
            step();
        end
        check_val("t5_no_done", dcnt, 0);
        run_op("t5_fresh", 8'h9C, 8'hB1);

        // T6: start held high, fresh random operands every cycle; one accept per W+2 edges.
        dcnt   = 0;
        last_e = -1;
        xa     = $urandom_range(255, 0);
        xb     = $urandom_range(255, 0);
        a      = xa[W-1:0];
        b      = xb[W-1:0];
        start  = 1'b1;
        for (e = 0; e < 200 * (W + 2); e++) begin
            if (e % (W + 2) == 0) begin
                qa.push_back(xa);
                qb.push_back(xb);
            end
            step();
            if (done) begin
                if (last_e < 0) begin
                    check_val("t6_first", e, W);
                end else begin
                    check_val("t6_spacing", e - last_e, W + 2);
                end
                last_e = e;
                dcnt++;
                if (qa.size() > 0) begin
                    check_val("t6_diff", 32'(diff), model_diff(qa[0], qb[0]));
                    check_val("t6_bor", 32'(borrow_out), model_bor(qa[0], qb[0]));
                    void'(qa.pop_front());
                    void'(qb.pop_front());
                end else begin
                    check_val("t6_unexpected_done", 32'(done), 32'd0);
                end
            end
            xa = $urandom_range(255, 0);
            xb = $urandom_range(255, 0);
            a  = xa[W-1:0];
            b  = xb[W-1:0];
        end
        start = 1'b0;
        for (int i = 0; i < 2 * (W + 2) && dcnt < 200; i++) begin
            if (done && qa.size() > 0) begin
                dcnt++;
                check_val("t6_tail_diff", 32'(diff), model_diff(qa[0], qb[0]));
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            step();
        end
        check_val("t6_count", dcnt, 200);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
